// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise_seq sequencer.
//   - instruction field widths: {opcode, Rn, imm}
//   - opcode constants for the attached bitwise machine
//   - sequencer FSM state encoding
//   - n clamping helper (instruction count limited to memory depth)
package bitwise_pkg;

  localparam int OPC_W  = 2;
  localparam int RN_W   = 2;
  localparam int IMM_W  = 8;
  localparam int OP_W   = OPC_W + RN_W;
  localparam int INSN_W = OP_W + IMM_W;
  localparam int ADDR_W = 4;
  localparam int N_W    = 5;

  localparam logic [OPC_W-1:0] OPC_MOV = 2'b00;
  localparam logic [OPC_W-1:0] OPC_XOR = 2'b01;
  localparam logic [OPC_W-1:0] OPC_ASL = 2'b10;
  localparam logic [OPC_W-1:0] OPC_SWP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Counts beyond the memory depth run the whole memory once.
  function automatic logic [N_W-1:0] clamp_n(input logic [N_W-1:0] n_in,
                                             input int unsigned  depth);
    if (32'(n_in) > depth) return N_W'(depth);
    return n_in;
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program memory for bitwise_seq: DEPTH x INSN_W, one synchronous write
// port and one combinational read port. Contents are not reset.
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data (instruction word)
//   i_raddr  read address
//   o_rdata  read data (combinational)
module seq_prog_mem
  import bitwise_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [INSN_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [INSN_W-1:0] o_rdata
);

  logic [INSN_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bitwise_seq.sv
// bitwise_seq: runs a short program of bitwise-machine instructions.
// Each instruction is issued with a one-cycle start strobe, then the
// sequencer waits for a rising edge of done (bounded by TMO cycles).
//   clk, reset        clock, synchronous active-high reset
//   load/ld_addr/ld_data  program memory write (ignored while busy)
//   start, n          run entries 0..n-1 (n clamped to DEPTH, n=0 -> fin)
//   s, op, in         strobe, {opcode,Rn}, immediate to bitwise machine
//   done, mout        completion flag and output bus from the machine
//   busy, fin, err    status: running, completion pulse, sticky timeout
//   result, pc        last captured mout, current instruction index
module bitwise_seq
  import bitwise_pkg::*;
#(
  parameter int TMO   = 64,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [INSN_W-1:0] ld_data,
  input  logic              start,
  input  logic [N_W-1:0]    n,
  output logic              s,
  output logic [OP_W-1:0]   op,
  output logic [IMM_W-1:0]  in,
  input  logic              done,
  input  logic [IMM_W-1:0]  mout,
  output logic              busy,
  output logic              fin,
  output logic              err,
  output logic [IMM_W-1:0]  result,
  output logic [ADDR_W-1:0] pc
);

  localparam int CNT_W = $clog2(TMO + 1);

  state_t             r_state;
  logic               r_s;
  logic [OP_W-1:0]    r_op;
  logic [IMM_W-1:0]   r_in;
  logic               r_fin;
  logic               r_err;
  logic [IMM_W-1:0]   r_result;
  logic [ADDR_W-1:0]  r_pc;
  logic [N_W-1:0]     r_n;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done_q;

  logic               w_cmpl;
  logic               w_last;
  logic               w_idle;
  logic               w_we;
  logic [ADDR_W-1:0]  w_raddr;
  logic [INSN_W-1:0]  w_insn;

  assign w_cmpl = done & ~r_done_q;
  assign w_last = (N_W'(r_pc) == (r_n - N_W'(1)));
  assign w_idle = (r_state == ST_IDLE) || (r_state == ST_ERR);
  assign w_we   = load && (w_idle || (r_state == ST_FIN));

  // Outputs are loaded on the edge that enters ISSUE, so the read address
  // must already point at the instruction about to be issued.
  assign w_raddr = (r_state == ST_WAIT) ? (r_pc + ADDR_W'(1)) : '0;

  seq_prog_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_raddr (w_raddr),
    .o_rdata (w_insn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_s      <= 1'b0;
      r_op     <= '0;
      r_in     <= '0;
      r_fin    <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_pc     <= '0;
      r_n      <= '0;
      r_cnt    <= '0;
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= done;
      r_s      <= 1'b0;
      r_fin    <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            r_err <= 1'b0;
            r_pc  <= '0;
            r_cnt <= '0;
            if (n == '0) begin
              r_fin   <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_n     <= clamp_n(n, DEPTH);
              r_s     <= 1'b1;
              r_op    <= w_insn[INSN_W-1:IMM_W];
              r_in    <= w_insn[IMM_W-1:0];
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over a timeout in the same cycle.
          if (w_cmpl) begin
            r_result <= mout;
            if (w_last) begin
              r_fin   <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_pc    <= r_pc + ADDR_W'(1);
              r_s     <= 1'b1;
              r_op    <= w_insn[INSN_W-1:IMM_W];
              r_in    <= w_insn[IMM_W-1:0];
              r_state <= ST_ISSUE;
            end
          end else if (r_cnt == CNT_W'(TMO - 1)) begin
            r_err   <= 1'b1;
            r_state <= ST_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s      = r_s;
  assign op     = r_op;
  assign in     = r_in;
  assign fin    = r_fin;
  assign err    = r_err;
  assign result = r_result;
  assign pc     = r_pc;
  assign busy   = ~w_idle;

endmodule

// File: tb/tb_bitwise_seq.sv
// Testbench for bitwise_seq with a behavioural bitwise machine attached.
module tb_bitwise_seq;
  import bitwise_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [INSN_W-1:0] ld_data = '0;
  logic              start = 1'b0;
  logic [N_W-1:0]    n = '0;
  logic              s;
  logic [OP_W-1:0]   op;
  logic [IMM_W-1:0]  in_bus;
  logic              done = 1'b0;
  logic [IMM_W-1:0]  mout = '0;
  logic              busy, fin, err;
  logic [IMM_W-1:0]  result;
  logic [ADDR_W-1:0] pc;

  bitwise_seq #(.TMO(64), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .load(load), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .n(n), .s(s), .op(op), .in(in_bus), .done(done), .mout(mout),
    .busy(busy), .fin(fin), .err(err), .result(result), .pc(pc)
  );

  always #5 clk = ~clk;

  // ---------------- bitwise machine model ----------------
  int          rsp_mode = 0;          // 0 normal, 1 done stuck high, 2 never done
  logic        pend = 1'b0;
  int          dly = 0;
  logic [3:0]  q_op = '0;
  logic [7:0]  q_in = '0;
  logic [7:0]  dp_r [4] = '{default: 8'h00};

  function automatic logic [7:0] alu(input logic [1:0] opc, input logic [7:0] a,
                                     input logic [7:0] imm);
    case (opc)
      OPC_MOV: return imm;
      OPC_XOR: return a ^ imm;
      OPC_ASL: return a << imm[2:0];
      default: return {a[3:0], a[7:4]};
    endcase
  endfunction

  always @(posedge clk) begin
    case (rsp_mode)
      1: begin done <= 1'b1; pend <= 1'b0; end
      2: begin done <= 1'b0; pend <= 1'b0; end
      default: begin
        done <= 1'b0;
        if (s) begin
          pend <= 1'b1; dly <= 2; q_op <= op; q_in <= in_bus;
        end else if (pend) begin
          if (dly == 0) begin
            done <= 1'b1;
            pend <= 1'b0;
            dp_r[q_op[1:0]] <= alu(q_op[3:2], dp_r[q_op[1:0]], q_in);
            mout <= alu(q_op[3:2], dp_r[q_op[1:0]], q_in);
          end else begin
            dly <= dly - 1;
          end
        end
      end
    endcase
  end

  // ---------------- monitors ----------------
  int         cyc = 0;
  logic       done_q = 1'b0;
  int         fin_cnt = 0;
  logic [3:0] s_op [$];
  logic [7:0] s_in [$];
  int         s_cyc [$];
  int         rise_cyc [$];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    done_q <= done;
    if (fin) fin_cnt <= fin_cnt + 1;
    if (s) begin
      s_op.push_back(op);
      s_in.push_back(in_bus);
      s_cyc.push_back(cyc);
    end
    if (done && !done_q) rise_cyc.push_back(cyc);
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic [1:0] opc, input logic [1:0] rn,
                                     input logic [7:0] imm);
    return {opc, rn, imm};
  endfunction

  task automatic load_word(input logic [3:0] a, input logic [11:0] d);
    @(negedge clk); load = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic start_prog(input logic [4:0] nn);
    @(negedge clk); start = 1'b1; n = nn;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input int bound, output logic ended);
    ended = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (fin || err) begin ended = 1'b1; break; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]        n;
    logic [3:0][11:0]  prog;
    logic [7:0]        exp_res;
    int                exp_pulses;
    logic [3:0]        exp_pc;
    int                reg_idx;
    logic [7:0]        reg_val;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int   base, rbase, fbase, np;
    logic ended;

    // R1 <- 42
    tbl[0] = '{5'd1, {12'h0, 12'h0, 12'h0, mk(OPC_MOV, 2'd1, 8'd42)},
               8'd42, 1, 4'd0, 1, 8'd42};
    // R1 <- 42, R2 <- 11
    tbl[1] = '{5'd2, {12'h0, 12'h0, mk(OPC_MOV, 2'd2, 8'd11), mk(OPC_MOV, 2'd1, 8'd42)},
               8'd11, 2, 4'd1, 2, 8'd11};
    // R0 <- F0, ^35 = C5, swap = 5C
    tbl[2] = '{5'd3, {12'h0, mk(OPC_SWP, 2'd0, 8'h00), mk(OPC_XOR, 2'd0, 8'h35),
                      mk(OPC_MOV, 2'd0, 8'hF0)},
               8'h5C, 3, 4'd2, 0, 8'h5C};
    // R3 <- 81, <<1 = 02
    tbl[3] = '{5'd2, {12'h0, 12'h0, mk(OPC_ASL, 2'd3, 8'h01), mk(OPC_MOV, 2'd3, 8'h81)},
               8'h02, 2, 4'd1, 3, 8'h02};
    // R2 <- 0F, <<4 = F0, ^FF = 0F, swap = F0
    tbl[4] = '{5'd4, {mk(OPC_SWP, 2'd2, 8'h00), mk(OPC_XOR, 2'd2, 8'hFF),
                      mk(OPC_ASL, 2'd2, 8'h04), mk(OPC_MOV, 2'd2, 8'h0F)},
               8'hF0, 4, 4'd3, 2, 8'hF0};

    // ---- reset state ----
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst_s", 32'(s), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fin", 32'(fin), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_op_in", {20'h0, op, in_bus}, 0);

    // ---- table-driven programs ----
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < int'(tbl[i].n); k++) load_word(4'(k), tbl[i].prog[k]);
      base  = s_op.size();
      rbase = rise_cyc.size();
      fbase = fin_cnt;
      start_prog(tbl[i].n);
      wait_end(200, ended);
      chk($sformatf("v%0d_ended", i), 32'(ended), 1);
      np = s_op.size() - base;
      chk($sformatf("v%0d_pulses", i), np, tbl[i].exp_pulses);
      for (int k = 0; k < np && k < tbl[i].exp_pulses; k++) begin
        chk($sformatf("v%0d_op%0d", i, k), 32'(s_op[base+k]), 32'(tbl[i].prog[k][11:8]));
        chk($sformatf("v%0d_in%0d", i, k), 32'(s_in[base+k]), 32'(tbl[i].prog[k][7:0]));
      end
      chk($sformatf("v%0d_result", i), 32'(result), 32'(tbl[i].exp_res));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
      chk($sformatf("v%0d_dpreg", i), 32'(dp_r[tbl[i].reg_idx]), 32'(tbl[i].reg_val));
      chk($sformatf("v%0d_fin_once", i), fin_cnt - fbase, 1);
      chk($sformatf("v%0d_err", i), 32'(err), 0);
      if (np >= 2 && rise_cyc.size() > rbase)
        chk($sformatf("v%0d_reissue_gap", i), s_cyc[base+1] - rise_cyc[rbase], 1);
    end

    // ---- timeout with done stuck high ----
    @(negedge clk); rsp_mode = 1;
    repeat (2) @(negedge clk);
    load_word(4'd0, mk(OPC_MOV, 2'd1, 8'd42));
    base = s_op.size();
    @(negedge clk); start = 1'b1; n = 5'd1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    chk("tmo_not_yet_err", 32'(err), 0);
    chk("tmo_not_yet_busy", 32'(busy), 1);
    @(posedge clk); #1;
    chk("tmo_err", 32'(err), 1);
    chk("tmo_busy", 32'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("tmo_s_pulses", s_op.size() - base, 1);
    chk("tmo_s_low", 32'(s), 0);
    chk("tmo_err_sticky", 32'(err), 1);
    @(negedge clk); rsp_mode = 0;
    repeat (2) @(negedge clk);
    @(negedge clk); start = 1'b1; n = 5'd1;
    @(posedge clk); #1;
    chk("tmo_err_cleared", 32'(err), 0);
    @(negedge clk); start = 1'b0;
    wait_end(200, ended);
    chk("tmo_rerun_ended", 32'(ended), 1);
    chk("tmo_rerun_result", 32'(result), 42);
    chk("tmo_rerun_err", 32'(err), 0);

    // ---- start/load ignored during WAIT, reset mid-WAIT ----
    @(negedge clk); rsp_mode = 2;
    load_word(4'd0, mk(OPC_MOV, 2'd1, 8'd42));
    load_word(4'd1, mk(OPC_MOV, 2'd2, 8'd11));
    base = s_op.size();
    start_prog(5'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; n = 5'd2; load = 1'b1; ld_addr = 4'd0; ld_data = 12'h3FF;
    @(negedge clk);
    start = 1'b0; load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("wait_start_ignored", s_op.size() - base, 1);
    chk("wait_busy", 32'(busy), 1);
    fbase = fin_cnt;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_s", 32'(s), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_pc", 32'(pc), 0);
    chk("midrst_result", 32'(result), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_fin", fin_cnt - fbase, 0);
    chk("midrst_no_s", s_op.size() - base, 1);
    @(negedge clk); rsp_mode = 0;
    base = s_op.size();
    start_prog(5'd1);
    wait_end(200, ended);
    chk("memkeep_ended", 32'(ended), 1);
    chk("memkeep_pulses", s_op.size() - base, 1);
    if (s_op.size() > base) begin
      chk("memkeep_op", 32'(s_op[base]), 32'h1);
      chk("memkeep_in", 32'(s_in[base]), 42);
    end
    chk("memkeep_result", 32'(result), 42);

    // ---- n = 0 ----
    base = s_op.size();
    @(negedge clk); start = 1'b1; n = 5'd0;
    @(posedge clk); #1;
    chk("n0_fin", 32'(fin), 1);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("n0_fin_off", 32'(fin), 0);
    chk("n0_busy", 32'(busy), 0);
    chk("n0_no_s", s_op.size() - base, 0);

    // ---- n = 20 clamps to 16 ----
    for (int k = 0; k < 16; k++) load_word(4'(k), mk(OPC_MOV, 2'd0, 8'(k)));
    base  = s_op.size();
    fbase = fin_cnt;
    start_prog(5'd20);
    wait_end(600, ended);
    chk("n20_ended", 32'(ended), 1);
    chk("n20_pulses", s_op.size() - base, 16);
    chk("n20_pc", 32'(pc), 15);
    chk("n20_result", 32'(result), 15);
    chk("n20_fin_once", fin_cnt - fbase, 1);
    if (s_op.size() >= base + 16)
      chk("n20_last_in", 32'(s_in[base+15]), 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
